// File: rtl/reg_write_ctrl_pkg.sv
// rtl/reg_write_ctrl_pkg.sv - shared widths and helpers for the register write path
`timescale 1ns/1ps
package reg_write_ctrl_pkg;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 5;
  localparam int REG_CNT = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_REG_ADDR = '0;

  // r0 is hardwired to zero when zero_ro is set, so it is never strobed or reported pending
  function automatic logic is_writable(input logic [ADDR_W-1:0] addr, input logic zero_ro);
    return !(zero_ro && (addr == ZERO_REG_ADDR));
  endfunction

endpackage

// File: rtl/reg_write_ctrl_decoder_5x32.sv
// rtl/reg_write_ctrl_decoder_5x32.sv - gate-level 5-to-32 one-hot decoder with enable
`timescale 1ns/1ps
module decoder_5x32 (
  output logic [31:0] y,
  input  logic [4:0]  a,
  input  logic        en
);

  logic [4:0] a_n;

  assign a_n = ~a;

  // Each output is an AND of en with one true/complement literal per address bit
  for (genvar i = 0; i < 32; i++) begin : g_row
    localparam logic [4:0] SEL = 5'(i);
    assign y[i] = en
                & (SEL[4] ? a[4] : a_n[4])
                & (SEL[3] ? a[3] : a_n[3])
                & (SEL[2] ? a[2] : a_n[2])
                & (SEL[1] ? a[1] : a_n[1])
                & (SEL[0] ? a[0] : a_n[0]);
  end

endmodule

// File: rtl/reg_write_ctrl.sv
// rtl/reg_write_ctrl.sv - in-order write buffer driving one-hot load strobes into the register bank
`timescale 1ns/1ps
module reg_write_ctrl
  import reg_write_ctrl_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter bit ZERO_RO = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic               hold,
  output logic [REG_CNT-1:0] reg_load,
  output logic [DATA_W-1:0]  reg_wdata,
  output logic [REG_CNT-1:0] pending
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [ADDR_W-1:0]  addr_q [DEPTH];
  logic [DATA_W-1:0]  data_q [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;
  logic               push;
  logic               pop;
  logic               load_en;
  logic [ADDR_W-1:0]  head_addr;
  logic [REG_CNT-1:0] dec_y;
  logic [REG_CNT-1:0] buf_pend;
  logic [PTR_W-1:0]   offs;

  // Ready comes from the registered count, so a pop at full frees the slot only on the next cycle
  assign wr_ready  = (count != FULL);
  assign push      = wr_valid && wr_ready;
  assign pop       = (count != '0) && !hold;
  assign head_addr = addr_q[rd_ptr];
  assign load_en   = pop && is_writable(head_addr, ZERO_RO);

  decoder_5x32 u_dec (
    .y  (dec_y),
    .a  (head_addr),
    .en (load_en)
  );

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr] <= wr_addr;
      data_q[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      reg_load  <= '0;
      reg_wdata <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      reg_load <= dec_y;
      if (pop) reg_wdata <= data_q[rd_ptr];
    end
  end

  // Entry i is live when its distance from the read pointer is below the fill count
  always_comb begin
    buf_pend = '0;
    offs     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offs = PTR_W'(i) - rd_ptr;
      if (({1'b0, offs} < count) && is_writable(addr_q[i], ZERO_RO))
        buf_pend[addr_q[i]] = 1'b1;
    end
  end

  assign pending = buf_pend | reg_load;

endmodule

// File: tb/tb_reg_write_ctrl.sv
// tb/tb_reg_write_ctrl.sv - scoreboard bench for reg_write_ctrl
`timescale 1ns/1ps
module tb_reg_write_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        hold = 1'b0;
  logic [31:0] reg_load;
  logic [31:0] reg_wdata;
  logic [31:0] pending;

  typedef struct {
    logic [31:0] load;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total = 0;
  int   stalls = 0;
  int   strobe_cnt = 0;

  reg_write_ctrl #(.DEPTH(2), .ZERO_RO(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .hold      (hold),
    .reg_load  (reg_load),
    .reg_wdata (reg_wdata),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    else
      passed++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds wr_valid until accepted; records the expected strobe when acceptance is certain
  task automatic send(input logic [4:0] a, input logic [31:0] d);
    int n;
    exp_t e;
    wr_addr  = a;
    wr_data  = d;
    wr_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!wr_ready && n < 50) begin
      n++;
      stalls++;
      @(negedge clk);
    end
    if (!wr_ready) begin
      chk("send_timeout", {31'd0, wr_ready}, 32'd1);
    end else if (a != 5'd0) begin
      e.load = 32'd1 << a;
      e.data = d;
      sb.push_back(e);
    end
    tick();
  endtask

  task automatic idle();
    wr_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && reg_load != 32'd0) begin
      strobe_cnt++;
      chk("onehot", {31'd0, $onehot(reg_load)}, 32'd1);
      if (sb.size() == 0) begin
        chk("spurious", reg_load, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("load", reg_load, e.load);
        chk("wdata", reg_wdata, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_load", reg_load, 32'd0);
    chk("rst_pend", pending, 32'd0);
    chk("rst_ready", {31'd0, wr_ready}, 32'd1);
    chk("rst_wdata", reg_wdata, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // single write latency
    send(5'd5, 32'hDEADBEEF);
    idle();
    chk("single_pend_k", pending, 32'h20);
    chk("single_load_k", reg_load, 32'd0);
    tick();
    chk("single_load", reg_load, 32'h20);
    chk("single_wdata", reg_wdata, 32'hDEADBEEF);
    chk("single_pend_strobe", pending, 32'h20);
    tick();
    chk("single_load_off", reg_load, 32'd0);
    chk("single_pend_off", pending, 32'd0);
    chk("single_wdata_hold", reg_wdata, 32'hDEADBEEF);

    // back-pressure with hold
    hold = 1'b1;
    send(5'd1, 32'h11);
    send(5'd2, 32'h22);
    idle();
    chk("bp_ready", {31'd0, wr_ready}, 32'd0);
    chk("bp_pend", pending, 32'h6);
    wr_valid = 1'b1;
    wr_addr  = 5'd3;
    wr_data  = 32'h33;
    repeat (2) tick();
    wr_valid = 1'b0;
    chk("bp_pend_after_ignored", pending, 32'h6);
    hold = 1'b0;
    tick();
    chk("bp_first", reg_load, 32'h2);
    chk("bp_ready_after_pop", {31'd0, wr_ready}, 32'd1);
    tick();
    chk("bp_second", reg_load, 32'h4);
    chk("bp_pend_second", pending, 32'h4);
    repeat (2) tick();
    chk("bp_drained", pending, 32'd0);

    // zero register write retires silently, later write still strobes
    send(5'd0, 32'h1234);
    idle();
    chk("zero_pend", pending, 32'd0);
    tick();
    chk("zero_load", reg_load, 32'd0);
    send(5'd9, 32'h99);
    idle();
    repeat (3) tick();

    // streaming
    stalls = 0;
    strobe_cnt = 0;
    for (int i = 0; i < 32; i++) send(5'(i), i * 32'h01010101);
    idle();
    repeat (4) tick();
    chk("stream_stalls", stalls, 32'd0);
    chk("stream_strobes", strobe_cnt, 32'd31);

    // same address twice
    send(5'd7, 32'hA);
    send(5'd7, 32'hB);
    idle();
    repeat (4) tick();

    // hold toggling while streaming random writes
    fork
      begin
        for (int i = 0; i < 24; i++) send(5'($urandom_range(0, 31)), $urandom);
        idle();
      end
      begin
        repeat (60) begin
          tick();
          hold = 1'($urandom_range(0, 1));
        end
        hold = 1'b0;
      end
    join
    repeat (6) tick();
    chk("random_drained", sb.size(), 32'd0);

    // reset with two entries queued
    hold = 1'b1;
    send(5'd3, 32'h3);
    send(5'd4, 32'h4);
    idle();
    chk("pre_rst_pend", pending, 32'h18);
    rst = 1'b1;
    #1;
    chk("mid_rst_load", reg_load, 32'd0);
    chk("mid_rst_pend", pending, 32'd0);
    chk("mid_rst_ready", {31'd0, wr_ready}, 32'd1);
    sb.delete();
    tick();
    rst = 1'b0;
    hold = 1'b0;
    strobe_cnt = 0;
    repeat (4) tick();
    chk("post_rst_strobes", strobe_cnt, 32'd0);
    chk("final_sb", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
